// File: rtl/medidor_periodo.sv
// -----------------------------------------------------------------------------
// medidor_periodo
//
// Period meter for a slow, free-running square wave (typically the output of
// one of the clock dividers). The monitored signal is brought into the clk
// domain through a two-flop synchroniser. A rising-edge detector then drives a
// small FSM that counts clk cycles between consecutive rising edges.
//
// Each completed measurement is published on `periodo` together with a
// one-cycle strobe. A tolerance flag tells whether the measurement lies within
// +/-TOLERANCIA of PERIODO_ESPERADO. A timeout level is raised when no edge
// arrives for LIMITE_TIMEOUT cycles.
//
// Parameters
//   LARGURA          width of the period counter and of `periodo`
//   PERIODO_ESPERADO nominal period, in clk cycles
//   TOLERANCIA       maximum allowed absolute deviation from the nominal period
//   LIMITE_TIMEOUT   cycles without an edge before timeout
//                    (2 <= LIMITE_TIMEOUT < 2**LARGURA)
//
// Ports
//   clk            in   system clock, all logic on its rising edge
//   reset          in   synchronous, active-high reset
//   sinal_in       in   monitored signal, asynchronous to clk
//   periodo        out  last measured period, in clk cycles
//   periodo_valido out  one-cycle strobe when `periodo` updates
//   periodo_ok     out  level, last measurement within tolerance
//   timeout        out  level, input considered stopped
// -----------------------------------------------------------------------------
module medidor_periodo #(
  parameter int LARGURA          = 16,
  parameter int PERIODO_ESPERADO = 128,
  parameter int TOLERANCIA       = 2,
  parameter int LIMITE_TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sinal_in,
  output logic [LARGURA-1:0] periodo,
  output logic               periodo_valido,
  output logic               periodo_ok,
  output logic               timeout
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  // The tolerance arithmetic is done one bit wider than the counter. The
  // subtraction can then never wrap, whatever the relation between the
  // counter value and the nominal period.
  localparam logic [LARGURA:0]   ESPERADO_EXT = (LARGURA+1)'(PERIODO_ESPERADO);
  localparam logic [LARGURA:0]   TOL_EXT      = (LARGURA+1)'(TOLERANCIA);
  localparam logic [LARGURA-1:0] LIMITE       = LARGURA'(LIMITE_TIMEOUT);
  localparam logic [LARGURA-1:0] UM           = LARGURA'(1);

  typedef enum logic [1:0] {
    ST_VAZIO,    // after reset: waiting for the first edge to start counting
    ST_MEDINDO,  // counting cycles since the last edge
    ST_TIMEOUT   // input stalled; waiting for an edge to restart
  } estado_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic s1;
  logic s2;
  logic ant;
  logic borda;

  // NOTE: every clocked register uses non-blocking assignments (<=). All
  // flops then sample their inputs from before the edge, so the three-stage
  // shift below behaves as a chain, not as a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      ant <= 1'b0;
    end else begin
      s1  <= sinal_in;
      s2  <= s1;
      ant <= s2;
    end
  end

  // s1/s2 form the metastability filter. `ant` is the previous s2 value, used
  // only for edge detection, so it never sees a metastable value.
  assign borda = s2 & ~ant;

  // ---------------------------------------------------------------------------
  // Tolerance check on the count that would be published this cycle
  // ---------------------------------------------------------------------------
  logic [LARGURA-1:0] contador;
  logic [LARGURA:0]   contador_ext;
  logic [LARGURA:0]   desvio;
  logic               dentro_tol;

  assign contador_ext = {1'b0, contador};
  assign desvio       = (contador_ext >= ESPERADO_EXT) ? (contador_ext - ESPERADO_EXT)
                                                       : (ESPERADO_EXT - contador_ext);
  assign dentro_tol   = (desvio <= TOL_EXT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  estado_t estado;
  estado_t estado_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= ST_VAZIO;
    end else begin
      estado <= estado_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and next values of the counter and registered outputs
  // ---------------------------------------------------------------------------
  logic [LARGURA-1:0] contador_nxt;
  logic [LARGURA-1:0] periodo_nxt;
  logic               valido_nxt;
  logic               ok_nxt;
  logic               timeout_nxt;

  // NOTE: every signal driven here gets a default value first. This lets no
  // branch leave a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_nxt   = estado;
    contador_nxt = contador;
    periodo_nxt  = periodo;
    valido_nxt   = 1'b0;
    ok_nxt       = periodo_ok;
    timeout_nxt  = timeout;

    unique case (estado)
      ST_VAZIO: begin
        // The first edge only opens a measurement; nothing is reported.
        if (borda) begin
          estado_nxt   = ST_MEDINDO;
          contador_nxt = UM;
        end
      end

      ST_MEDINDO: begin
        // An edge takes priority over the limit check. A period of exactly
        // LIMITE_TIMEOUT is therefore reported normally.
        if (borda) begin
          periodo_nxt  = contador;
          valido_nxt   = 1'b1;
          ok_nxt       = dentro_tol;
          contador_nxt = UM;
        end else if (contador == LIMITE) begin
          estado_nxt  = ST_TIMEOUT;
          timeout_nxt = 1'b1;
          ok_nxt      = 1'b0;
        end else begin
          contador_nxt = contador + UM;
        end
      end

      ST_TIMEOUT: begin
        // The period spanning the stall is meaningless. The edge therefore
        // only restarts counting and clears the timeout; there is no strobe.
        if (borda) begin
          estado_nxt   = ST_MEDINDO;
          contador_nxt = UM;
          timeout_nxt  = 1'b0;
        end
      end

      default: begin
        estado_nxt = ST_VAZIO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      contador       <= '0;
      periodo        <= '0;
      periodo_valido <= 1'b0;
      periodo_ok     <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      contador       <= contador_nxt;
      periodo        <= periodo_nxt;
      periodo_valido <= valido_nxt;
      periodo_ok     <= ok_nxt;
      timeout        <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_medidor_periodo.sv
// -----------------------------------------------------------------------------
// tb_medidor_periodo
//
// Drives one shared square-wave stimulus into two instances of medidor_periodo:
//   dut_a  default parameters (LIMITE_TIMEOUT = 1023)
//   dut_b  LIMITE_TIMEOUT = 200, for the edge-versus-limit corner
//
// Each rising edge driven on sinal_in predicts the strobe it causes, if any.
// The prediction holds the cycle, the period and the tolerance flag. It goes
// into a per-instance queue and is popped when the instance strobes.
// -----------------------------------------------------------------------------
module tb_medidor_periodo;

  localparam int W        = 16;
  localparam int NOMINAL  = 128;
  localparam int TOL      = 2;
  localparam int LIMITE_A = 1023;
  localparam int LIMITE_B = 200;
  localparam int LATENCIA = 3;  // rise driven -> strobe visible, in cycles

  logic         clk = 1'b0;
  logic         reset;
  logic         sinal_in;
  logic [W-1:0] periodo_a;
  logic [W-1:0] periodo_b;
  logic         valido_a;
  logic         valido_b;
  logic         ok_a;
  logic         ok_b;
  logic         timeout_a;
  logic         timeout_b;

  medidor_periodo dut_a (
    .clk            (clk),
    .reset          (reset),
    .sinal_in       (sinal_in),
    .periodo        (periodo_a),
    .periodo_valido (valido_a),
    .periodo_ok     (ok_a),
    .timeout        (timeout_a)
  );

  medidor_periodo #(.LIMITE_TIMEOUT(LIMITE_B)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .sinal_in       (sinal_in),
    .periodo        (periodo_b),
    .periodo_valido (valido_b),
    .periodo_ok     (ok_b),
    .timeout        (timeout_b)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge = number of posedges so far.
  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    int ciclo;
    int periodo;
    bit ok;
  } esperado_t;

  esperado_t q_a[$];
  esperado_t q_b[$];
  esperado_t e_a;
  esperado_t e_b;

  int total = 0;
  int bad   = 0;
  int last_rise  = 0;
  bit rise_valid = 1'b0;
  int t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit dentro(input int p);
    int d;
    d = (p > NOMINAL) ? p - NOMINAL : NOMINAL - p;
    return d <= TOL;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a rising edge and predict the strobe, if any, for each instance.
  // There is no strobe for the first edge after reset. There is also none
  // when the gap exceeded the instance's timeout limit.
  task automatic rise();
    int iv;
    sinal_in = 1'b1;
    if (rise_valid) begin
      iv = ncyc - last_rise;
      if (iv <= LIMITE_A) q_a.push_back('{ciclo: ncyc + LATENCIA, periodo: iv, ok: dentro(iv)});
      if (iv <= LIMITE_B) q_b.push_back('{ciclo: ncyc + LATENCIA, periodo: iv, ok: dentro(iv)});
    end
    last_rise  = ncyc;
    rise_valid = 1'b1;
  endtask

  task automatic square(input int p, input int n, input int hi);
    repeat (n) begin
      rise();
      tick(hi);
      sinal_in = 1'b0;
      tick(p - hi);
    end
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (valido_a) begin
      if (q_a.size() == 0) check("spurious_strobe_a", valido_a, 0);
      else begin
        e_a = q_a.pop_front();
        check("strobe_cycle_a", ncyc, e_a.ciclo);
        check("periodo_a", periodo_a, e_a.periodo);
        check("periodo_ok_a", ok_a, e_a.ok);
      end
    end else if (q_a.size() > 0 && q_a[0].ciclo <= ncyc) begin
      check("missed_strobe_a", valido_a, 1);
      void'(q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (valido_b) begin
      if (q_b.size() == 0) check("spurious_strobe_b", valido_b, 0);
      else begin
        e_b = q_b.pop_front();
        check("strobe_cycle_b", ncyc, e_b.ciclo);
        check("periodo_b", periodo_b, e_b.periodo);
        check("periodo_ok_b", ok_b, e_b.ok);
      end
    end else if (q_b.size() > 0 && q_b[0].ciclo <= ncyc) begin
      check("missed_strobe_b", valido_b, 1);
      void'(q_b.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    reset    = 1'b1;
    sinal_in = 1'b0;
    tick(2);
    check("reset_periodo", periodo_a, 0);
    check("reset_valido", valido_a, 0);
    check("reset_ok", ok_a, 0);
    check("reset_timeout", timeout_a, 0);
    reset = 1'b0;

    // Nominal clk/128 waveform.
    square(128, 5, 64);
    check("nominal_timeout", timeout_a, 0);

    // Tolerance boundaries.
    square(130, 2, 65);
    square(131, 2, 65);
    square(126, 2, 63);
    square(125, 2, 62);
    square(128, 2, 64);

    // Timeout: last edge, then hold low.
    rise();
    t0 = last_rise;
    tick(64);
    sinal_in = 1'b0;
    tick(t0 + 1025 - ncyc);
    check("timeout_not_yet", timeout_a, 0);
    tick(1);
    check("timeout_asserted", timeout_a, 1);
    check("timeout_ok_low", ok_a, 0);
    check("timeout_periodo_held", periodo_a, 128);
    check("timeout_b_asserted", timeout_b, 1);

    // Recovery: first edge clears timeout without strobe.
    rise();
    tick(2);
    check("recovery_timeout_still", timeout_a, 1);
    tick(1);
    check("recovery_timeout_clear", timeout_a, 0);
    tick(61);
    sinal_in = 1'b0;
    tick(64);
    square(128, 2, 64);

    // Edge versus limit (dut_b, limit 200).
    square(200, 3, 100);
    rise();
    tick(3);
    check("edge_wins_b", timeout_b, 0);
    tick(97);
    sinal_in = 1'b0;
    tick(101);
    rise();
    tick(2);
    check("limit_timeout_b", timeout_b, 1);
    tick(1);
    check("limit_timeout_clear_b", timeout_b, 0);
    check("limit_periodo_held_b", periodo_b, 200);
    check("limit_a_no_timeout", timeout_a, 0);
    tick(97);
    sinal_in = 1'b0;
    tick(100);
    square(200, 2, 100);

    // Mid-run reset, 50 cycles into a period (input low by then).
    rise();
    tick(32);
    sinal_in = 1'b0;
    tick(18);
    reset = 1'b1;
    tick(1);
    check("midreset_periodo", periodo_a, 0);
    check("midreset_valido", valido_a, 0);
    check("midreset_ok", ok_a, 0);
    check("midreset_timeout", timeout_a, 0);
    check("midreset_timeout_b", timeout_b, 0);
    reset      = 1'b0;
    rise_valid = 1'b0;
    tick(77);
    square(128, 2, 32);
    rise();
    tick(10);

    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
